regs_wb_ctrl: RTL
=================

// Module: regs_wb_ctrl
// PURPOSE
//  Write-back controller and interlock for the DLX register file (regs).
//  - Shares the single regs write port (WB/Rd/reg_s) between the ALU and MEM result sources via round-robin arbitration.
//  - Keeps a per-register busy scoreboard.
//  - Stalls issue on RAW/WAW hazards against pending writes.
// PARAMETERS
//  NREGS  32  number of architectural registers; r0 hardwired to zero
//  AW     5   register index width, $clog2(NREGS)
//  DW     32  data width
// PORTS
//  clk        in   1   clock; all state changes on the rising edge
//  rst_n      in   1   reset, asynchronous assert, active-low
//  iss_valid  in   1   decode presents an instruction
//  iss_rs1    in   AW  source 1 index
//  iss_rs2    in   AW  source 2 index
//  iss_rd     in   AW  destination index
//  iss_wr     in   1   instruction writes iss_rd
//  iss_stall  out  1   hold decode; the instruction is not accepted this cycle
//  alu_valid  in   1   ALU result ready
//  alu_rd     in   AW  ALU result destination
//  alu_data   in   DW  ALU result data
//  alu_ready  out  1   ALU result accepted this cycle
//  mem_valid  in   1   load result ready
//  mem_rd     in   AW  load destination
//  mem_data   in   DW  load data
//  mem_ready  out  1   load result accepted this cycle
//  WB         out  1   regs write enable, registered
//  Rd         out  AW  regs write index, registered
//  reg_s      out  DW  regs write data, registered
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - busy[]=0; WB=0, Rd=0, reg_s=0; rr_last=MEM, so the first conflict goes to ALU.
//   - Reset mid-operation drops every pending write and clears all busy bits.
//  Hazards (combinational)
//   - hz = busy[iss_rs1] | busy[iss_rs2] | (iss_wr & busy[iss_rd]).
//   - iss_stall = iss_valid & hz. Index 0 never reads as busy.
//  Issue
//   - An instruction is accepted when iss_valid & !iss_stall.
//   - If accepted and iss_wr & iss_rd!=0, busy[iss_rd] is set at the edge.
//  Arbitration (combinational)
//   - Only one source valid: that source wins.
//   - Both valid: the source that did not win last conflict wins; rr_last updates only on a conflict.
//   - Loser sees ready=0 and holds its valid/rd/data stable until granted.
//   - ready is independent of any downstream state; the port accepts one result per cycle.
//  Write-back pipeline (latency 1)
//   - Grant in cycle N -> WB=1 with Rd/reg_s = winner rd/data in cycle N+1.
//   - No grant -> WB=0; Rd/reg_s hold their last value.
//   - A granted result with rd==0 is accepted (ready=1) but produces WB=0.
//  Busy clear
//   - busy[Rd] clears at the edge that ends the cycle in which WB=1.
//   - A reader of that register is stalled through the WB cycle and accepted the following cycle.
//  Simultaneous events
//   - Issue set and WB clear can never hit the same index (WAW stall), so both updates apply.
//   - A result arriving for a non-busy rd is written anyway; the busy bit stays 0.
// STRUCTURE
//  - Shared package dlx_pkg: AW/DW/NREGS constants and typedef src_e {SRC_ALU, SRC_MEM}.
//  - One sub-module, rr_arb2: two-request round-robin arbiter, grant plus rr_last flop.
//  - Scoreboard, hazard logic and write-back registers stay in regs_wb_ctrl.
//  - Top-level integration instantiates regs with .WB/.Rd/.reg_s driven by this block.
// TESTING
//  1 Reset: assert rst_n=0 mid-burst
//    -> WB=0, Rd=0, reg_s=0, iss_stall=0 for any sources.
//  2 Issue rd=7, then alu_valid rd=7 data=111111 one cycle later
//    -> alu_ready=1; next cycle WB=1, Rd=7, reg_s=111111; busy[7] clear after.
//  3 Issue rd=7; next cycle issue rs1=7
//    -> iss_stall=1 until the cycle after WB=1 for Rd=7, then accepted.
//  4 alu_valid rd=3 and mem_valid rd=10 in the same cycle, twice
//    -> ALU wins first (WB Rd=3), MEM wins second (Rd=10); loser holds data.
//  5 alu_valid rd=0 data=222222
//    -> alu_ready=1, WB stays 0; iss rs1=0 rs2=0 never stalls.
//  6 Issue rd=13 then issue rd=13 again (WAW)
//    -> second stalls until the first write-back completes, then busy[13] set again.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX constants and the write-back source encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dlx_pkg;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam int DW    = 32;

  // Write-back result sources that share the single regs write port.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;
endpackage

// File: rtl/regs_wb_ctrl_if.sv
// Bundle of the issue, ALU-result, load-result and regs write-port signals.
// Latency: n/a (wiring only).
// Backpressure: iss_stall holds decode; alu_ready/mem_ready grant one result per cycle.
// Ports: slave = controller side, master = decode / execute / regs side.
interface regs_wb_ctrl_if;
  import dlx_pkg::*;

  logic          iss_valid;
  logic [AW-1:0] iss_rs1;
  logic [AW-1:0] iss_rs2;
  logic [AW-1:0] iss_rd;
  logic          iss_wr;
  logic          iss_stall;

  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;

  logic          mem_valid;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;

  logic          WB;
  logic [AW-1:0] Rd;
  logic [DW-1:0] reg_s;

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
    output iss_stall,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output WB, Rd, reg_s
  );

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
    input  iss_stall,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  WB, Rd, reg_s
  );
endinterface

// File: rtl/regs_wb_ctrl_rr_arb2.sv
// Two-request round-robin arbiter between the ALU and MEM result sources.
// Latency: grant is combinational; rr_last updates at the edge, only on a conflict.
// Backpressure: the loser of a conflict gets no grant and must hold its request.
// Ports: clk, rst_n, req_alu/req_mem in, gnt_alu/gnt_mem out.
module rr_arb2
  import dlx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu,
  output logic gnt_mem
);

  src_e rr_last_q, rr_last_d;

  always_comb begin
    gnt_alu   = 1'b0;
    gnt_mem   = 1'b0;
    rr_last_d = rr_last_q;
    if (req_alu && req_mem) begin
      // Conflict: the source that lost last time wins now.
      if (rr_last_q == SRC_MEM) begin
        gnt_alu   = 1'b1;
        rr_last_d = SRC_ALU;
      end else begin
        gnt_mem   = 1'b1;
        rr_last_d = SRC_MEM;
      end
    end else begin
      gnt_alu = req_alu;
      gnt_mem = req_mem;
    end
  end

  // Reset to MEM so the first conflict after reset goes to the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last_q <= SRC_MEM;
    else        rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/regs_wb_ctrl.sv
// Write-back controller: arbitrates ALU/MEM results onto the regs write port,
// keeps a per-register busy scoreboard and stalls issue on RAW/WAW hazards.
// Latency: grant in cycle N -> WB/Rd/reg_s in cycle N+1; stall is combinational.
// Backpressure: iss_stall holds decode; the ungranted result source sees ready=0.
// Ports: clk, rst_n, bus (regs_wb_ctrl_if.slave: iss_*, alu_*, mem_*, WB/Rd/reg_s).
module regs_wb_ctrl
  import dlx_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  regs_wb_ctrl_if.slave  bus
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             wb_q, wb_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [DW-1:0]    data_q, data_d;

  logic             gnt_alu, gnt_mem;
  logic             hz, accept;
  logic [AW-1:0]    win_rd;
  logic [DW-1:0]    win_data;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_alu (bus.alu_valid),
    .req_mem (bus.mem_valid),
    .gnt_alu (gnt_alu),
    .gnt_mem (gnt_mem)
  );

  // r0 is hardwired to zero and must never report busy.
  function automatic logic is_busy(input logic [NREGS-1:0] b, input logic [AW-1:0] idx);
    return (idx != '0) && b[idx];
  endfunction

  always_comb begin
    hz = is_busy(busy_q, bus.iss_rs1) | is_busy(busy_q, bus.iss_rs2) |
         (bus.iss_wr & is_busy(busy_q, bus.iss_rd));
    bus.iss_stall = bus.iss_valid & hz;
    accept        = bus.iss_valid & ~hz;
    bus.alu_ready = gnt_alu;
    bus.mem_ready = gnt_mem;
  end

  always_comb begin
    win_rd   = gnt_mem ? bus.mem_rd   : bus.alu_rd;
    win_data = gnt_mem ? bus.mem_data : bus.alu_data;
    wb_d     = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    // A granted result for r0 is consumed but never written.
    if ((gnt_alu || gnt_mem) && win_rd != '0) begin
      wb_d   = 1'b1;
      rd_d   = win_rd;
      data_d = win_data;
    end
  end

  // Clear and set never collide on one index: a pending writer stalls WAW issue.
  always_comb begin
    busy_d = busy_q;
    if (wb_q) busy_d[rd_q] = 1'b0;
    if (accept && bus.iss_wr && bus.iss_rd != '0) busy_d[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      wb_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      wb_q   <= wb_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign bus.WB    = wb_q;
  assign bus.Rd    = rd_q;
  assign bus.reg_s = data_q;

endmodule
